// File: rtl/taxi_pcie_vpd_pkg.sv
// Shared constants and types for the multi-function VPD capability.
// Optional APB stall timeout: define TAXI_PCIE_VPD_TIMEOUT_EN.
package taxi_pcie_vpd_pkg;

  localparam int FLAG_BIT = 31;
  localparam int ADDR_LSB = 16;

  localparam logic [7:0] VPD_CAP_ID = 8'h03;
  localparam logic [31:0] VPD_ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_t;

  function automatic int func_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/taxi_apb_if.sv
// AMBA APB interface bundle with master/slave views.
// Carries optional user sideband fields.
interface taxi_apb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int PAUSER_W = 1,
  parameter int PWUSER_W = 1,
  parameter int PRUSER_W = 1,
  parameter int PBUSER_W = 1
);

  logic [ADDR_W-1:0] paddr;
  logic [2:0] pprot;
  logic psel;
  logic penable;
  logic pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic pready;
  logic [DATA_W-1:0] prdata;
  logic pslverr;
  logic [PAUSER_W-1:0] pauser;
  logic [PWUSER_W-1:0] pwuser;
  logic [PRUSER_W-1:0] pruser;
  logic [PBUSER_W-1:0] pbuser;

  modport mst (
    output paddr, pprot, psel, penable, pwrite,
    output pwdata, pstrb, pauser, pwuser,
    input pready, prdata, pslverr, pruser, pbuser
  );

  modport slv (
    input paddr, pprot, psel, penable, pwrite,
    input pwdata, pstrb, pauser, pwuser,
    output pready, prdata, pslverr, pruser, pbuser
  );

endinterface

// File: rtl/taxi_pcie_vpd_func.sv
// Per-function VPD address/flag/data registers with write acceptance.
// A function stays busy from an accepted R0 write until its APB completion.
module taxi_pcie_vpd_func
  import taxi_pcie_vpd_pkg::*;
#(
  parameter int VPD_ADDR_W = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_wr,
  input  logic                  r1_wr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_be,
  input  logic                  cpl,
  input  logic [31:0]           cpl_data,
  output logic [VPD_ADDR_W-1:0] addr,
  output logic [31:0]           data,
  output logic                  flag,
  output logic                  busy
);

  logic r0_acc;
  logic r1_acc;

  assign r0_acc = r0_wr & wr_be[3] & wr_be[2] & ~busy;
  assign r1_acc = r1_wr & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      data <= '0;
      flag <= 1'b0;
      busy <= 1'b0;
    end else begin
      if (r0_acc) begin
        addr <= wr_data[ADDR_LSB +: VPD_ADDR_W];
        flag <= wr_data[FLAG_BIT];
        busy <= 1'b1;
      end else if (cpl) begin
        // flag toggles: a write clears it, a read sets it
        flag <= ~flag;
        busy <= 1'b0;
        if (!flag) begin
          data <= cpl_data;
        end
      end
      if (r1_acc) begin
        for (int i = 0; i < 4; i++) begin
          if (wr_be[i]) begin
            data[i*8 +: 8] <= wr_data[i*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/taxi_pcie_us_vpd_mf.sv
// Multi-function VPD capability sharing one APB master across functions.
// Define TAXI_PCIE_VPD_TIMEOUT_EN to abort stalled APB transfers.
module taxi_pcie_us_vpd_mf
  import taxi_pcie_vpd_pkg::*;
#(
  parameter int         FUNC_CNT    = 2,
  parameter logic [7:0] CAP_ID      = VPD_CAP_ID,
  parameter logic [7:0] CAP_OFFSET  = 8'hB0,
  parameter logic [7:0] CAP_NEXT    = 8'h00,
  parameter int         VPD_ADDR_W  = 15,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  taxi_apb_if.mst     m_apb,
  input  logic        cfg_ext_read_received,
  input  logic        cfg_ext_write_received,
  input  logic [9:0]  cfg_ext_register_number,
  input  logic [7:0]  cfg_ext_function_number,
  input  logic [31:0] cfg_ext_write_data,
  input  logic [3:0]  cfg_ext_write_byte_enable,
  output logic [31:0] cfg_ext_read_data,
  output logic        cfg_ext_read_data_valid
);

  localparam int FUNC_W = func_w(FUNC_CNT);
  localparam int AW = m_apb.ADDR_W;
  localparam int PW = FUNC_W + VPD_ADDR_W;
  localparam logic [9:0] REG0 = 10'(CAP_OFFSET >> 2);
  localparam logic [9:0] REG1 = REG0 + 10'd1;

  if (m_apb.DATA_W != 32) begin : g_chk_data
    $fatal(1, "APB DATA_W must be 32");
  end
  if (AW < PW) begin : g_chk_addr
    $fatal(1, "APB ADDR_W too narrow for function and VPD address");
  end

  logic [VPD_ADDR_W-1:0] f_addr [FUNC_CNT];
  logic [31:0]           f_data [FUNC_CNT];
  logic [FUNC_CNT-1:0]   f_flag;
  logic [FUNC_CNT-1:0]   f_busy;
  logic [FUNC_CNT-1:0]   r0_wr;
  logic [FUNC_CNT-1:0]   r1_wr;
  logic [FUNC_CNT-1:0]   cpl_vec;

  logic              fn_ok;
  logic [FUNC_W-1:0] fidx;
  logic              r0_hit;
  logic              r1_hit;

  apb_state_t        state;
  apb_state_t        state_nxt;
  logic [FUNC_W-1:0] grant;
  logic [FUNC_W-1:0] ptr;
  logic [FUNC_W-1:0] rr_sel;
  logic              rr_any;
  logic              cpl;
  logic              cpl_err;
  logic              tmo;
  logic [31:0]       cpl_data;
  logic [PW-1:0]     paddr_int;
  logic [31:0]       rd_val;

  assign fn_ok  = cfg_ext_function_number < 8'(FUNC_CNT);
  assign fidx   = cfg_ext_function_number[FUNC_W-1:0];
  assign r0_hit = cfg_ext_register_number == REG0;
  assign r1_hit = cfg_ext_register_number == REG1;

  always_comb begin
    r0_wr = '0;
    r1_wr = '0;
    cpl_vec = '0;
    for (int j = 0; j < FUNC_CNT; j++) begin
      if (cfg_ext_write_received && cfg_ext_function_number == 8'(j)) begin
        r0_wr[j] = r0_hit;
        r1_wr[j] = r1_hit;
      end
      cpl_vec[j] = cpl && grant == FUNC_W'(j);
    end
  end

  for (genvar g = 0; g < FUNC_CNT; g++) begin : g_func
    taxi_pcie_vpd_func #(
      .VPD_ADDR_W(VPD_ADDR_W)
    ) u_func (
      .clk      (clk),
      .rst      (rst),
      .r0_wr    (r0_wr[g]),
      .r1_wr    (r1_wr[g]),
      .wr_data  (cfg_ext_write_data),
      .wr_be    (cfg_ext_write_byte_enable),
      .cpl      (cpl_vec[g]),
      .cpl_data (cpl_data),
      .addr     (f_addr[g]),
      .data     (f_data[g]),
      .flag     (f_flag[g]),
      .busy     (f_busy[g])
    );
  end

  // Round-robin: first busy index above ptr, else wrap to lowest busy
  always_comb begin
    logic hi_any;
    logic [FUNC_W-1:0] hi_sel;
    logic [FUNC_W-1:0] lo_sel;
    hi_any = 1'b0;
    hi_sel = '0;
    lo_sel = '0;
    rr_any = 1'b0;
    for (int j = FUNC_CNT - 1; j >= 0; j--) begin
      if (f_busy[j]) begin
        rr_any = 1'b1;
        if (j > int'(ptr)) begin
          hi_any = 1'b1;
          hi_sel = FUNC_W'(j);
        end else begin
          lo_sel = FUNC_W'(j);
        end
      end
    end
    rr_sel = hi_any ? hi_sel : lo_sel;
  end

  assign cpl      = (state == ST_ACCESS) & (m_apb.pready | tmo);
  assign cpl_err  = m_apb.pready ? m_apb.pslverr : 1'b1;
  assign cpl_data = cpl_err ? VPD_ERR_DATA : m_apb.prdata;

`ifdef TAXI_PCIE_VPD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != CNT_W'(TIMEOUT_CYC)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo = (state == ST_ACCESS) && (tmo_cnt >= CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (rr_any) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (cpl) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      ptr <= '0;
    end else if (state == ST_IDLE && rr_any) begin
      grant <= rr_sel;
      ptr <= rr_sel;
    end
  end

  assign paddr_int = {grant, f_addr[grant]};

  always_comb begin
    m_apb.psel    = state != ST_IDLE;
    m_apb.penable = state == ST_ACCESS;
    m_apb.paddr   = AW'(paddr_int);
    m_apb.pwrite  = f_flag[grant];
    m_apb.pwdata  = f_data[grant];
    m_apb.pprot   = 3'b010;
    m_apb.pstrb   = '1;
    m_apb.pauser  = '0;
    m_apb.pwuser  = '0;
  end

  always_comb begin
    rd_val = '0;
    if (fn_ok && r0_hit) begin
      rd_val = {f_flag[fidx], 15'(f_addr[fidx]), CAP_NEXT, CAP_ID};
    end else if (fn_ok && r1_hit) begin
      rd_val = f_data[fidx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ext_read_data <= '0;
      cfg_ext_read_data_valid <= 1'b0;
    end else begin
      cfg_ext_read_data <= cfg_ext_read_received ? rd_val : 32'h0;
      cfg_ext_read_data_valid <= cfg_ext_read_received & fn_ok & (r0_hit | r1_hit);
    end
  end

  logic unused_ok;
  assign unused_ok = ^{m_apb.pruser, m_apb.pbuser};

endmodule

// File: tb/tb_taxi_pcie_us_vpd_mf.sv
// Self-checking bench: random config traffic against a register/APB model.
// Honours TAXI_PCIE_VPD_TIMEOUT_EN for the stall-timeout scenario.
module tb_taxi_pcie_us_vpd_mf;

  localparam int FN = 3;
  localparam int AW = 20;
  localparam int TMO = 32;
  localparam logic [9:0] R0 = 10'h2C;
  localparam logic [9:0] R1 = 10'h2D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd_rx = 1'b0;
  logic        wr_rx = 1'b0;
  logic [9:0]  reg_no = '0;
  logic [7:0]  fn_no = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe = '0;
  logic [31:0] rdata;
  logic        rvalid;

  taxi_apb_if #(.DATA_W(32), .ADDR_W(AW)) apb ();

  taxi_pcie_us_vpd_mf #(
    .FUNC_CNT(FN),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .m_apb                     (apb),
    .cfg_ext_read_received     (rd_rx),
    .cfg_ext_write_received    (wr_rx),
    .cfg_ext_register_number   (reg_no),
    .cfg_ext_function_number   (fn_no),
    .cfg_ext_write_data        (wdata),
    .cfg_ext_write_byte_enable (wbe),
    .cfg_ext_read_data         (rdata),
    .cfg_ext_read_data_valid   (rvalid)
  );

  int checks = 0;
  int failures = 0;

  // APB slave model
  typedef struct {
    logic [AW-1:0] paddr;
    logic          wr;
    logic [31:0]   wdata;
    logic [2:0]    prot;
    logic [3:0]    strb;
  } xfer_t;

  xfer_t log_q[$];
  logic [31:0] smem [int];
  logic hold = 1'b0;
  logic err_next = 1'b0;
  int delay = 0;
  int wcnt = 0;
  int proto_err = 0;
  logic prev_cpl = 1'b0;
  logic prev_psel = 1'b0;
  logic prev_pen = 1'b0;

  function automatic logic [31:0] sval(input logic [AW-1:0] a);
    if (smem.exists(int'(a))) return smem[int'(a)];
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign apb.pready = apb.psel & apb.penable & ~hold & (wcnt >= delay);
  assign apb.pslverr = apb.pready & err_next;
  assign apb.prdata = apb.pready ? sval(apb.paddr) : 32'h0;
  assign apb.pruser = '0;
  assign apb.pbuser = '0;

  always @(posedge clk) begin
    if (apb.psel && apb.penable && apb.pready) begin
      log_q.push_back('{apb.paddr, apb.pwrite, apb.pwdata, apb.pprot, apb.pstrb});
      if (apb.pwrite && !apb.pslverr) smem[int'(apb.paddr)] = apb.pwdata;
      wcnt <= 0;
      delay <= $urandom_range(0, 2);
    end else if (apb.psel && apb.penable) begin
      wcnt <= wcnt + 1;
    end
    if (!rst) begin
      if (prev_cpl && apb.psel) proto_err <= proto_err + 1;
      if (!prev_psel && apb.psel && apb.penable) proto_err <= proto_err + 1;
      if (prev_psel && !prev_pen && !(apb.psel && apb.penable)) proto_err <= proto_err + 1;
    end
    prev_cpl <= apb.psel & apb.penable & apb.pready;
    prev_psel <= apb.psel;
    prev_pen <= apb.penable;
  end

  // Reference register model
  logic [14:0] m_addr [FN];
  logic [31:0] m_data [FN];
  logic        m_flag [FN];

  function automatic logic [31:0] m_r0(input int f);
    return {m_flag[f], m_addr[f], 8'h00, 8'h03};
  endfunction

  function automatic logic [AW-1:0] m_paddr(input int f);
    return AW'(f * 32768 + int'(m_addr[f]));
  endfunction

  function automatic int rr_next(input int p, input bit pend [FN]);
    for (int d = 1; d <= FN; d++) begin
      if (pend[(p + d) % FN]) return (p + d) % FN;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < FN; i++) begin
      m_addr[i] = '0;
      m_data[i] = '0;
      m_flag[i] = 1'b0;
    end
  endtask

  // Apply the effect of a completed transfer for function f
  task automatic model_cpl(input int f, input bit err);
    if (m_flag[f]) begin
      m_flag[f] = 1'b0;
    end else begin
      m_data[f] = err ? 32'hFFFF_FFFF : sval(m_paddr(f));
      m_flag[f] = 1'b1;
    end
  endtask

  task automatic cfg_wr(input int f, input logic [9:0] r, input logic [31:0] d,
                        input logic [3:0] be);
    @(negedge clk);
    wr_rx = 1'b1;
    fn_no = 8'(f);
    reg_no = r;
    wdata = d;
    wbe = be;
    @(negedge clk);
    wr_rx = 1'b0;
  endtask

  task automatic cfg_rd(input int f, input logic [9:0] r, output logic [31:0] d,
                        output logic v);
    @(negedge clk);
    rd_rx = 1'b1;
    fn_no = 8'(f);
    reg_no = r;
    @(negedge clk);
    rd_rx = 1'b0;
    v = rvalid;
    d = rdata;
  endtask

  task automatic wait_xfers(input int n);
    int cyc = 0;
    while (log_q.size() < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (log_q.size() < n) begin
      failures++;
      $display("FAIL wait_xfers got=%0d want=%0d", log_q.size(), n);
    end
  endtask

  task automatic chk_regs(input int f, input string tag);
    logic [31:0] d;
    logic v;
    cfg_rd(f, R0, d, v);
    checks++;
    if (v !== 1'b1 || d !== m_r0(f)) begin
      failures++;
      $display("FAIL %s_r0 f=%0d got=%h/%b want=%h/1", tag, f, d, v, m_r0(f));
    end
    cfg_rd(f, R1, d, v);
    checks++;
    if (v !== 1'b1 || d !== m_data[f]) begin
      failures++;
      $display("FAIL %s_r1 f=%0d got=%h/%b want=%h/1", tag, f, d, v, m_data[f]);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (apb.psel !== 1'b0 || apb.penable !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_out psel=%b pen=%b v=%b d=%h want 0", apb.psel, apb.penable,
               rvalid, rdata);
    end
    rst = 1'b0;
    model_clear();
    cfg_rd(0, R0, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0000_0003) begin
      failures++;
      $display("FAIL reset_r0 got=%h/%b want=00000003/1", d, v);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin
      failures++;
      $display("FAIL valid_pulse got=%b want=0", rvalid);
    end
    cfg_rd(2, R1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL reset_r1 got=%h/%b want=0/1", d, v);
    end
    cfg_rd(FN, R0, d, v);
    checks++;
    if (v !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL bad_func got=%h/%b want=0/0", d, v);
    end
    cfg_rd(0, R1 + 10'd1, d, v);
    checks++;
    if (v !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL bad_reg got=%h/%b want=0/0", d, v);
    end
  endtask

  task automatic test_write_xfer();
    int n = log_q.size();
    cfg_wr(1, R1, 32'hDEAD_BEEF, 4'hF);
    m_data[1] = 32'hDEAD_BEEF;
    cfg_wr(1, R0, 32'h8012_0000, 4'hF);
    m_addr[1] = 15'h0012;
    m_flag[1] = 1'b1;
    wait_xfers(n + 1);
    checks++;
    if (log_q.size() > n && (log_q[n].paddr !== 20'h0_8012 || log_q[n].wr !== 1'b1 ||
        log_q[n].wdata !== 32'hDEAD_BEEF || log_q[n].prot !== 3'b010 ||
        log_q[n].strb !== 4'hF)) begin
      failures++;
      $display("FAIL wr_xfer got=%h/%b/%h/%b/%h want=08012/1/deadbeef/010/f",
               log_q[n].paddr, log_q[n].wr, log_q[n].wdata, log_q[n].prot, log_q[n].strb);
    end
    model_cpl(1, 1'b0);
    chk_regs(1, "wr_done");
    cfg_wr(1, R1, 32'h1122_3344, 4'b0101);
    m_data[1] = 32'hDE22_BE44;
    cfg_wr(1, R0, 32'h8055_0000, 4'b0100);
    repeat (6) @(negedge clk);
    checks++;
    if (log_q.size() != n + 1) begin
      failures++;
      $display("FAIL be_ignore xfers=%0d want=%0d", log_q.size(), n + 1);
    end
    chk_regs(1, "be_partial");
  endtask

  task automatic test_rr_order();
    int n = log_q.size();
    int p;
    int ord [FN];
    bit pend [FN];
    hold = 1'b1;
    for (int i = 0; i < FN; i++) m_addr[i] = 15'($urandom);
    cfg_wr(2, R0, {1'b0, m_addr[2], 16'h0}, 4'hC);
    m_flag[2] = 1'b0;
    repeat (4) @(negedge clk);
    cfg_wr(1, R0, {1'b0, m_addr[1], 16'h0}, 4'hF);
    cfg_wr(0, R0, {1'b0, m_addr[0], 16'h0}, 4'hF);
    m_flag[1] = 1'b0;
    m_flag[0] = 1'b0;
    repeat (3) @(negedge clk);
    hold = 1'b0;
    ord[0] = 2;
    pend = '{1, 1, 0};
    p = 2;
    for (int k = 1; k < FN; k++) begin
      ord[k] = rr_next(p, pend);
      pend[ord[k]] = 0;
      p = ord[k];
    end
    wait_xfers(n + FN);
    for (int k = 0; k < FN; k++) begin
      checks++;
      if (log_q.size() > n + k && (log_q[n+k].paddr !== m_paddr(ord[k]) ||
          log_q[n+k].wr !== 1'b0)) begin
        failures++;
        $display("FAIL rr_order k=%0d got=%h want=%h", k, log_q[n+k].paddr,
                 m_paddr(ord[k]));
      end
    end
    for (int i = 0; i < FN; i++) begin
      model_cpl(i, 1'b0);
      chk_regs(i, "rr");
    end
  endtask

  task automatic test_busy_ignore();
    int n = log_q.size();
    logic [14:0] a = 15'h1A5;
    hold = 1'b1;
    cfg_wr(0, R0, {1'b0, a, 16'h0}, 4'hF);
    m_addr[0] = a;
    m_flag[0] = 1'b0;
    repeat (4) @(negedge clk);
    cfg_wr(0, R0, 32'hC0F0_0000, 4'hF);
    cfg_wr(0, R1, 32'h0BAD_F00D, 4'hF);
    chk_regs(0, "busy");
    repeat (3) @(negedge clk);
    hold = 1'b0;
    wait_xfers(n + 1);
    repeat (10) @(negedge clk);
    checks++;
    if (log_q.size() != n + 1 || log_q[n].paddr !== m_paddr(0)) begin
      failures++;
      $display("FAIL busy_xfers n=%0d want=%0d addr=%h want=%h", log_q.size(), n + 1,
               log_q[n].paddr, m_paddr(0));
    end
    model_cpl(0, 1'b0);
    chk_regs(0, "busy_done");
  endtask

  task automatic test_slverr();
    int n = log_q.size();
    err_next = 1'b1;
    m_addr[2] = 15'h3FF0;
    cfg_wr(2, R0, {1'b0, m_addr[2], 16'h0}, 4'hF);
    m_flag[2] = 1'b0;
    wait_xfers(n + 1);
    model_cpl(2, 1'b1);
    chk_regs(2, "slverr_rd");
    m_addr[1] = 15'h0777;
    cfg_wr(1, R0, {1'b1, m_addr[1], 16'h0}, 4'hF);
    m_flag[1] = 1'b1;
    wait_xfers(n + 2);
    err_next = 1'b0;
    model_cpl(1, 1'b1);
    chk_regs(1, "slverr_wr");
  endtask

  task automatic test_timeout();
    int n = log_q.size();
    hold = 1'b1;
    m_addr[0] = 15'h0444;
    cfg_wr(0, R0, {1'b0, m_addr[0], 16'h0}, 4'hF);
    m_flag[0] = 1'b0;
    repeat (TMO + 10) @(negedge clk);
`ifdef TAXI_PCIE_VPD_TIMEOUT_EN
    checks++;
    if (apb.psel !== 1'b0 || log_q.size() != n) begin
      failures++;
      $display("FAIL timeout_psel got=%b xfers=%0d want=0/%0d", apb.psel, log_q.size(), n);
    end
    hold = 1'b0;
    model_cpl(0, 1'b1);
`else
    checks++;
    if (apb.psel !== 1'b1 || apb.penable !== 1'b1) begin
      failures++;
      $display("FAIL stall_psel got=%b/%b want=1/1", apb.psel, apb.penable);
    end
    hold = 1'b0;
    wait_xfers(n + 1);
    model_cpl(0, 1'b0);
`endif
    chk_regs(0, "timeout");
  endtask

  task automatic test_reset_mid();
    int n = log_q.size();
    hold = 1'b1;
    cfg_wr(1, R1, 32'h5555_AAAA, 4'hF);
    cfg_wr(1, R0, 32'h0123_0000, 4'hF);
    repeat (4) @(negedge clk);
    checks++;
    if (apb.psel !== 1'b1) begin
      failures++;
      $display("FAIL mid_psel got=%b want=1", apb.psel);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (apb.psel !== 1'b0 || apb.penable !== 1'b0) begin
      failures++;
      $display("FAIL mid_drop got=%b/%b want=0/0", apb.psel, apb.penable);
    end
    hold = 1'b0;
    model_clear();
    repeat (5) @(negedge clk);
    checks++;
    if (log_q.size() != n) begin
      failures++;
      $display("FAIL mid_nocpl xfers=%0d want=%0d", log_q.size(), n);
    end
    chk_regs(1, "mid_clr");
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int f = $urandom_range(0, FN - 1);
      int op = $urandom_range(0, 3);
      int n = log_q.size();
      logic [31:0] d = $urandom;
      logic [3:0] be = 4'($urandom);
      logic [31:0] rd;
      logic v;
      err_next = ($urandom_range(0, 4) == 0);
      if (op == 0) begin
        cfg_wr(f, R1, d, be);
        for (int b = 0; b < 4; b++) if (be[b]) m_data[f][b*8 +: 8] = d[b*8 +: 8];
      end else if (op == 3) begin
        if ($urandom_range(0, 1) == 1) cfg_rd(FN + int'($urandom_range(0, 3)), R0, rd, v);
        else cfg_rd(f, R0 - 10'd1, rd, v);
        checks++;
        if (v !== 1'b0 || rd !== 32'h0) begin
          failures++;
          $display("FAIL rnd_noresp it=%0d got=%h/%b want=0/0", it, rd, v);
        end
      end else begin
        if ($urandom_range(0, 2) != 0) be[3:2] = 2'b11;
        cfg_wr(f, R0, d, be);
        if (be[3:2] == 2'b11) begin
          m_addr[f] = d[30:16];
          m_flag[f] = d[31];
          wait_xfers(n + 1);
          checks++;
          if (log_q.size() > n && (log_q[n].paddr !== m_paddr(f) ||
              log_q[n].wr !== d[31] || (d[31] && log_q[n].wdata !== m_data[f]))) begin
            failures++;
            $display("FAIL rnd_xfer it=%0d got=%h/%b/%h want=%h/%b/%h", it, log_q[n].paddr,
                     log_q[n].wr, log_q[n].wdata, m_paddr(f), d[31], m_data[f]);
          end
          model_cpl(f, err_next);
        end else begin
          repeat (5) @(negedge clk);
          checks++;
          if (log_q.size() != n) begin
            failures++;
            $display("FAIL rnd_ignore it=%0d xfers=%0d want=%0d", it, log_q.size(), n);
          end
        end
      end
      chk_regs(f, "rnd");
    end
    err_next = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = log_q.size();
    m_addr[0] = 15'h0101;
    m_addr[1] = 15'h0202;
    cfg_wr(0, R0, {1'b1, m_addr[0], 16'h0}, 4'hF);
    cfg_wr(1, R0, {1'b0, m_addr[1], 16'h0}, 4'hF);
    m_flag[0] = 1'b1;
    m_flag[1] = 1'b0;
    wait_xfers(n + 2);
    checks++;
    if (log_q.size() > n + 1 && (log_q[n].paddr !== m_paddr(0) ||
        log_q[n+1].paddr !== m_paddr(1))) begin
      failures++;
      $display("FAIL b2b_order got=%h,%h want=%h,%h", log_q[n].paddr, log_q[n+1].paddr,
               m_paddr(0), m_paddr(1));
    end
    model_cpl(0, 1'b0);
    model_cpl(1, 1'b0);
    chk_regs(0, "b2b");
    chk_regs(1, "b2b");
    checks++;
    if (proto_err != 0) begin
      failures++;
      $display("FAIL apb_protocol violations=%0d want=0", proto_err);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_xfer();
    test_rr_order();
    test_busy_ignore();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
